// File: rtl/imem_load_ctrl.sv
// AXI4-Lite write-only loader for instruction memory: fills the 256-word
// program window and owns the core hold / fetch-flush controls.
module imem_load_ctrl #(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter bit          HOLD_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_awaddr,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wvalid,
  output logic        s_wready,
  output logic [1:0]  s_bresp,
  output logic        s_bvalid,
  input  logic        s_bready,
  input  logic        fetch_req,
  output logic        imem_read_en,
  output logic        imem_write_en,
  output logic [7:0]  imem_write_addr,
  output logic [31:0] imem_write_data,
  output logic        imem_flush,
  output logic        cpu_hold
);

  typedef enum logic [1:0] {IDLE, WRITE, RESP} state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_e      state_q, state_d;
  logic        rdy_q;
  logic        aw_held_q, aw_held_d;
  logic        w_held_q, w_held_d;
  logic [31:0] off_q, off_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strb_q, strb_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        hold_q, hold_d;
  logic        flush_q, flush_d;

  logic aw_hs, w_hs;
  logic aligned, is_word, is_ctrl, word_ok;

  // Latched address is stored as an offset so the reset value gives write address 0.
  assign aligned = (off_q[1:0] == 2'b00);
  assign is_word = (off_q[31:10] == '0);
  assign is_ctrl = (off_q == 32'h0000_0400);
  assign word_ok = is_word && aligned && (strb_q == 4'hF);

  assign aw_hs = s_awvalid && s_awready;
  assign w_hs  = s_wvalid && s_wready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rdy_q     <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      off_q     <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      bresp_q   <= RESP_OKAY;
      hold_q    <= HOLD_ON_RESET;
      flush_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdy_q     <= 1'b1;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      off_q     <= off_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      bresp_q   <= bresp_d;
      hold_q    <= hold_d;
      flush_q   <= flush_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    off_d     = off_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    bresp_d   = bresp_q;
    hold_d    = hold_q;
    flush_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          off_d     = s_awaddr - BASE_ADDR;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = s_wdata;
          strb_d   = s_wstrb;
        end
        if (aw_held_d && w_held_d) state_d = WRITE;
      end
      WRITE: begin
        state_d = RESP;
        if (word_ok) begin
          hold_d  = 1'b1;
          bresp_d = RESP_OKAY;
        end else if (is_ctrl) begin
          bresp_d = RESP_OKAY;
          if (wdata_q[0]) begin
            hold_d = 1'b1;
          end else if (hold_q) begin
            hold_d  = 1'b0;
            flush_d = 1'b1;
          end
        end else begin
          bresp_d = RESP_SLVERR;
        end
      end
      RESP: begin
        if (s_bready) begin
          state_d   = IDLE;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_awready       = rdy_q && (state_q == IDLE) && !aw_held_q;
    s_wready        = rdy_q && (state_q == IDLE) && !w_held_q;
    s_bvalid        = (state_q == RESP);
    s_bresp         = bresp_q;
    imem_write_en   = (state_q == WRITE) && word_ok;
    imem_write_addr = off_q[9:2];
    imem_write_data = wdata_q;
    imem_flush      = flush_q;
    cpu_hold        = hold_q;
    imem_read_en    = fetch_req && !hold_q;
  end

endmodule
